// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared seven-segment definitions: blank pattern, segment bit order and hex glyphs.
// Glyphs are {g,f,e,d,c,b,a} active-low; the dp bit is added by the scanner.
package seg7_scan_ctrl_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_t;

  function automatic logic [3:0] nibble_of(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side bundle of the seven-segment scanner: display word, masks and pin outputs.
interface seg7_scan_ctrl_if;
  logic        en;
  logic [31:0] value_in;
  logic        value_load;
  logic [7:0]  blank_mask;
  logic [7:0]  dp_mask;
  logic [7:0]  blink_mask;
  logic [2:0]  digit_sel;
  logic [7:0]  seg_n;
  logic        frame_done;

  modport master (
    output en, value_in, value_load, blank_mask, dp_mask, blink_mask,
    input  digit_sel, seg_n, frame_done
  );

  modport slave (
    input  en, value_in, value_load, blank_mask, dp_mask, blink_mask,
    output digit_sel, seg_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational 4-bit value to seven-segment glyph lookup, full 0-F table.
module hex_to_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_0;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with ghost blanking, blink and
// tear-free display word update at frame boundaries.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int GHOST_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int FRM_W   = $clog2(BLINK_FRAMES + 1);
  localparam int GHOST_W = (GHOST_CYC > 0) ? $clog2(GHOST_CYC + 1) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0]   FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [GHOST_W-1:0] GHOST_LOAD = (GHOST_CYC > 0) ? GHOST_W'(GHOST_CYC - 1) : '0;
  localparam logic               GHOST_ON   = (GHOST_CYC > 0);

  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [2:0]         digit, digit_nxt;
  logic [GHOST_W-1:0] ghost_cnt, ghost_nxt;
  logic [FRM_W-1:0]   frm_cnt, frm_nxt;
  blink_phase_t       phase, phase_nxt;
  logic [31:0]        pending, pending_nxt;
  logic [31:0]        active, active_nxt;
  logic [7:0]         seg, seg_nxt;
  logic               frame_done, frame_done_nxt;

  logic               div_wrap, frame_wrap, ghost_on_nxt, dark;
  logic [3:0]         nib;
  logic [6:0]         glyph;

  hex_to_seg7 u_glyph (
    .nibble (nib),
    .glyph  (glyph)
  );

  always_comb begin
    div_wrap       = bus.en && (div_cnt == DIV_LAST);
    frame_wrap     = div_wrap && (digit == 3'd7);
    div_nxt        = div_cnt;
    digit_nxt      = digit;
    ghost_nxt      = ghost_cnt;
    ghost_on_nxt   = 1'b0;
    frm_nxt        = frm_cnt;
    phase_nxt      = phase;
    pending_nxt    = bus.value_load ? bus.value_in : pending;
    active_nxt     = active;
    frame_done_nxt = frame_wrap;

    if (bus.en) begin
      div_nxt = div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        digit_nxt    = digit + 3'd1;
        ghost_nxt    = GHOST_LOAD;
        ghost_on_nxt = GHOST_ON;
      end else if (ghost_cnt != '0) begin
        ghost_nxt    = ghost_cnt - GHOST_W'(1);
        ghost_on_nxt = 1'b1;
      end
    end

    // A load landing on the wrap edge bypasses pending so it is not a frame late.
    if (frame_wrap) begin
      active_nxt = bus.value_load ? bus.value_in : pending;
      if (frm_cnt == FRM_LAST) begin
        frm_nxt   = '0;
        phase_nxt = (phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frm_nxt = frm_cnt + FRM_W'(1);
      end
    end

    // Pattern is built from next-state values so it lines up with digit_sel.
    nib  = nibble_of(active_nxt, digit_nxt);
    dark = bus.blank_mask[digit_nxt] ||
           (bus.blink_mask[digit_nxt] && (phase_nxt == BLINK_OFF));

    seg_nxt = SEG_BLANK;
    if (bus.en && !ghost_on_nxt && !dark) begin
      seg_nxt[SEG_G:SEG_A] = glyph;
      seg_nxt[SEG_DP]      = ~bus.dp_mask[digit_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      digit      <= 3'd0;
      ghost_cnt  <= '0;
      frm_cnt    <= '0;
      phase      <= BLINK_ON;
      pending    <= '0;
      active     <= '0;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      digit      <= digit_nxt;
      ghost_cnt  <= ghost_nxt;
      frm_cnt    <= frm_nxt;
      phase      <= phase_nxt;
      pending    <= pending_nxt;
      active     <= active_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  assign bus.digit_sel  = digit;
  assign bus.seg_n      = seg;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4, GHOST_CYC=1, BLINK_FRAMES=2.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   c = 0;
  int   k;
  int   f;
  logic [7:0] exp_seg;
  logic [7:0] pat [16];

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.SCAN_DIV(4), .GHOST_CYC(1), .BLINK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    c++;
  endtask

  initial begin
    pat[0] = 8'hC0; pat[1] = 8'hF9; pat[2] = 8'hA4; pat[3] = 8'hB0;
    pat[4] = 8'h99; pat[5] = 8'h92; pat[6] = 8'h82; pat[7] = 8'hF8;
    pat[8] = 8'h80; pat[9] = 8'h90; pat[10] = 8'h88; pat[11] = 8'h83;
    pat[12] = 8'hC6; pat[13] = 8'hA1; pat[14] = 8'h86; pat[15] = 8'h8E;

    rst = 1'b1;
    bus.en = 1'b1;
    bus.value_in = 32'h0;
    bus.value_load = 1'b0;
    bus.blank_mask = 8'h00;
    bus.dp_mask = 8'h00;
    bus.blink_mask = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_digit", bus.digit_sel, 0);
    chk("rst_seg", bus.seg_n, 8'hFF);
    chk("rst_fd", bus.frame_done, 0);
    rst = 1'b0;

    // scan cadence, ghost cycle and frame_done timing with a zero word
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("scan_digit", bus.digit_sel, (c / 4) % 8);
      chk("scan_seg", bus.seg_n, (c % 4 == 0) ? 8'hFF : 8'hC0);
      chk("scan_fd", bus.frame_done, (c % 32 == 0) ? 1 : 0);
    end

    // mid-frame load only shows from the next frame
    bus.value_in = 32'h76543210;
    bus.value_load = 1'b1;
    tick();
    bus.value_load = 1'b0;
    bus.value_in = 32'h0;
    while (c < 95) begin
      tick();
      k = (c / 4) % 8;
      if (c % 4 == 1) chk("load_seg", bus.seg_n, (c < 64) ? 8'hC0 : pat[k]);
      if (c % 4 == 0) chk("load_ghost", bus.seg_n, 8'hFF);
    end

    // load coinciding with the wrap edge goes straight to the active word
    bus.value_in = 32'hFFFFFFFF;
    bus.value_load = 1'b1;
    tick();
    bus.value_load = 1'b0;
    bus.value_in = 32'h0;
    chk("wrap_fd", bus.frame_done, 1);
    while (c < 128) begin
      tick();
      if (c % 4 == 1) chk("wrapload_seg", bus.seg_n, 8'h8E);
    end

    // blink / blank / dp masks; blink phase is off in frames 2,3,6,7
    bus.blink_mask = 8'h01;
    bus.blank_mask = 8'h80;
    bus.dp_mask = 8'h02;
    while (c < 256) begin
      tick();
      if (c % 4 == 1) begin
        k = (c / 4) % 8;
        f = c / 32;
        if (k == 7) exp_seg = 8'hFF;
        else if (k == 0) exp_seg = ((f / 2) % 2 == 1) ? 8'hFF : 8'h8E;
        else if (k == 1) exp_seg = 8'h0E;
        else exp_seg = 8'h8E;
        chk("mask_seg", bus.seg_n, exp_seg);
      end
    end
    bus.blink_mask = 8'h00;
    bus.blank_mask = 8'h00;
    bus.dp_mask = 8'h00;

    // freeze mid-digit, then resume the remaining cycles
    tick();
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_digit", bus.digit_sel, 0);
      chk("hold_seg", bus.seg_n, 8'hFF);
      chk("hold_fd", bus.frame_done, 0);
    end
    bus.en = 1'b1;
    tick();
    chk("resume_digit", bus.digit_sel, 0);
    chk("resume_seg", bus.seg_n, 8'h8E);
    tick();
    chk("resume_next_digit", bus.digit_sel, 1);
    chk("resume_next_seg", bus.seg_n, 8'hFF);

    // reset mid-frame clears active and pending words
    bus.value_in = 32'h12345678;
    bus.value_load = 1'b1;
    tick();
    bus.value_load = 1'b0;
    bus.value_in = 32'h0;
    while (c < 309) tick();
    chk("pre_rst_digit", bus.digit_sel, 5);
    chk("pre_rst_seg", bus.seg_n, 8'hB0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_digit", bus.digit_sel, 0);
    chk("mid_rst_seg", bus.seg_n, 8'hFF);
    chk("mid_rst_fd", bus.frame_done, 0);
    rst = 1'b0;
    c = 0;
    while (c < 33) begin
      tick();
      if (c == 32) chk("post_rst_fd", bus.frame_done, 1);
      if (c % 32 == 1) begin
        chk("post_rst_digit", bus.digit_sel, 0);
        chk("post_rst_seg", bus.seg_n, 8'hC0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
